// File: rtl/grant_sequencer_pkg.sv
// Shared types and constants for the grant sequencer and its arbiter.
package grant_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } gseq_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/grant_sequencer_if.sv
// Request/grant bundle between the requesters and the grant sequencer.
interface grant_sequencer_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req_in;
    logic             mode_in;
    logic [N_REQ-1:0] gnt_out;
    logic [ID_W-1:0]  gnt_id_out;
    logic             gnt_valid_out;

    // Requester side: drives requests and mode, observes the grant.
    modport master (
        output req_in,
        output mode_in,
        input  gnt_out,
        input  gnt_id_out,
        input  gnt_valid_out
    );

    // Arbiter side: observes requests, drives the grant.
    modport slave (
        input  req_in,
        input  mode_in,
        output gnt_out,
        output gnt_id_out,
        output gnt_valid_out
    );
endinterface

// File: rtl/grant_sequencer_arb_pick.sv
// Combinational picker: first set candidate at or after a start index,
// wrapping modulo N_REQ. Fixed mode ignores the start index and scans from 0.
module arb_pick
    import grant_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] cand,
    input  logic [ID_W-1:0]  start,
    input  logic             mode,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    logic [ID_W-1:0]  eff_start;
    logic [N_REQ-1:0] rotated;
    logic [ID_W:0]    src_idx [N_REQ];
    logic [ID_W-1:0]  offset;
    logic [ID_W:0]    back_sum;

    assign eff_start = (mode == MODE_FIXED) ? '0 : start;

    // rotated[gi] holds the candidate gi positions after the start index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [ID_W:0] raw_sum;
            assign raw_sum     = (ID_W+1)'(gi) + {1'b0, eff_start};
            assign src_idx[gi] = (raw_sum >= (ID_W+1)'(N_REQ)) ? raw_sum - (ID_W+1)'(N_REQ) : raw_sum;
            assign rotated[gi] = cand[src_idx[gi][ID_W-1:0]];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the nearest candidate after start.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = ID_W'(i);
            end
        end
    end

    // Rotate the winning offset back into an absolute requester index.
    always_comb begin
        back_sum = {1'b0, offset} + {1'b0, eff_start};
        if (back_sum >= (ID_W+1)'(N_REQ)) begin
            back_sum = back_sum - (ID_W+1)'(N_REQ);
        end
        winner = back_sum[ID_W-1:0];
    end

endmodule

// File: rtl/grant_sequencer.sv
// Registered 4-requester arbiter with hold timeout and a one-cycle dead gap
// between owners, so decoded grants never overlap.
module grant_sequencer
    import grant_seq_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int MAX_HOLD = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    grant_sequencer_if.slave bus
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(N_REQ - 1);

    gseq_state_e       state_reg,    state_next;
    logic [N_REQ-1:0]  gnt_reg,      gnt_next;
    logic [ID_W-1:0]   gnt_id_reg,   gnt_id_next;
    logic              valid_reg,    valid_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [ID_W-1:0]   last_id_reg,  last_id_next;
    logic [N_REQ-1:0]  mask_reg,     mask_next;

    logic [N_REQ-1:0]  cand;
    logic [ID_W-1:0]   rr_start;
    logic [ID_W-1:0]   winner;
    logic              found;

    // A preempted holder stays masked for the single gap cycle.
    assign cand     = bus.req_in & ~mask_reg;
    assign rr_start = (last_id_reg == LAST_IDX) ? '0 : last_id_reg + ID_W'(1);

    arb_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb_pick (
        .cand   (cand),
        .start  (rr_start),
        .mode   (bus.mode_in),
        .winner (winner),
        .found  (found)
    );

    // State register; reset wins over any grant activity.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            valid_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            last_id_reg  <= LAST_IDX;
            mask_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            valid_reg    <= valid_next;
            hold_cnt_reg <= hold_cnt_next;
            last_id_reg  <= last_id_next;
            mask_reg     <= mask_next;
        end
    end

    // Next-state: arbitrate from IDLE/GAP, release or preempt from BUSY.
    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        valid_next    = valid_reg;
        hold_cnt_next = hold_cnt_reg;
        last_id_next  = last_id_reg;
        mask_next     = mask_reg;

        case (state_reg)
            IDLE, GAP: begin
                mask_next = '0;
                if (found) begin
                    state_next         = BUSY;
                    gnt_next           = '0;
                    gnt_next[winner]   = 1'b1;
                    gnt_id_next        = winner;
                    valid_next         = 1'b1;
                    hold_cnt_next      = '0;
                    last_id_next       = winner;
                end else begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    valid_next = 1'b0;
                end
            end
            BUSY: begin
                if (!bus.req_in[gnt_id_reg]) begin
                    // Release takes precedence over a coincident timeout.
                    state_next = GAP;
                    gnt_next   = '0;
                    valid_next = 1'b0;
                    mask_next  = '0;
                end else if ((hold_cnt_reg == HOLD_LAST) && ((bus.req_in & ~gnt_reg) != '0)) begin
                    state_next = GAP;
                    gnt_next   = '0;
                    valid_next = 1'b0;
                    mask_next  = gnt_reg;
                end else if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                valid_next = 1'b0;
                mask_next  = '0;
            end
        endcase
    end

    assign bus.gnt_out       = gnt_reg;
    assign bus.gnt_id_out    = gnt_id_reg;
    assign bus.gnt_valid_out = valid_reg;

endmodule

// File: tb/tb_grant_sequencer.sv
// Directed plus random stimulus against a behavioural ownership model.
module tb_grant_sequencer;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;

    grant_sequencer_if #(.N_REQ(N_REQ)) bus ();

    grant_sequencer #(
        .N_REQ    (N_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: who owns the grant, how long, who is excluded for one gap.
    int m_owner = -1;
    int m_held  = 0;
    int m_id    = 0;
    int m_last  = N_REQ - 1;
    int m_excl  = -1;

    logic       prev_valid = 1'b0;
    logic [1:0] prev_id    = 2'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input int cand, input bit rr, input int last);
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = rr ? (last + 1 + k) % N_REQ : k;
            if (((cand >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_update();
        int req;
        req = int'(bus.req_in);
        if (rst) begin
            m_owner = -1; m_held = 0; m_id = 0; m_last = N_REQ - 1; m_excl = -1;
        end else if (m_owner >= 0) begin
            int others;
            others = req & ~(1 << m_owner);
            if (((req >> m_owner) & 1) == 0) begin
                m_owner = -1; m_excl = -1;
            end else if (m_held == MAX_HOLD - 1 && others != 0) begin
                m_excl = m_owner; m_owner = -1;
            end else if (m_held < MAX_HOLD - 1) begin
                m_held++;
            end
        end else begin
            int cand, w;
            cand = req;
            if (m_excl >= 0) cand = cand & ~(1 << m_excl);
            w = pick(cand, bus.mode_in, m_last);
            m_excl = -1;
            if (w >= 0) begin
                m_owner = w; m_id = w; m_last = w; m_held = 0;
            end
        end
    endtask

    task automatic tick();
        int exp_gnt;
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
        $display("cyc=%0d rst=%b req=%b mode=%b gnt=%b id=%0d valid=%b", cyc, rst,
                 bus.req_in, bus.mode_in, bus.gnt_out, bus.gnt_id_out, bus.gnt_valid_out);
        chk("gnt", 32'(bus.gnt_out), 32'(exp_gnt));
        chk("gnt_id", 32'(bus.gnt_id_out), 32'(m_id));
        chk("valid", 32'(bus.gnt_valid_out), 32'(m_owner >= 0));
        chk("onehot0", 32'($onehot0(bus.gnt_out)), 32'd1);
        chk("valid_eq_or", 32'(bus.gnt_valid_out == (|bus.gnt_out)), 32'd1);
        chk("no_b2b", 32'(prev_valid && bus.gnt_valid_out && (prev_id != bus.gnt_id_out)), 32'd0);
        prev_valid = bus.gnt_valid_out;
        prev_id    = bus.gnt_id_out;
    endtask

    function automatic logic [31:0] rr_pattern(input int i);
        if (i % 9 == 8) return 32'd0;
        return 32'(1 << ((i / 9) % 4));
    endfunction

    initial begin
        rst = 1'b1;
        bus.req_in  = 4'b1111;
        bus.mode_in = 1'b0;

        // Reset held with all requests asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt", 32'(bus.gnt_out), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("rst_release", 32'(bus.gnt_out), 32'h1);
        bus.req_in = 4'b0000;
        tick();
        chk("release_gap", 32'(bus.gnt_out), 32'd0);
        tick();

        // Fixed priority.
        bus.req_in = 4'b0110;
        tick();
        chk("fixed_gnt", 32'(bus.gnt_out), 32'h2);
        chk("fixed_id", 32'(bus.gnt_id_out), 32'd1);
        bus.req_in = 4'b0000;
        tick();
        chk("fixed_gap", 32'(bus.gnt_out), 32'd0);
        tick();

        // Timeout preemption between two fixed-mode requesters.
        bus.req_in = 4'b0011;
        for (int i = 0; i < 19; i++) begin
            logic [31:0] e;
            tick();
            if (i < 8) e = 32'h1;
            else if (i == 8 || i == 17) e = 32'h0;
            else if (i < 17) e = 32'h2;
            else e = 32'h1;
            chk("timeout_seq", 32'(bus.gnt_out), e);
        end

        // Round robin among all four.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mode_in = 1'b1;
        bus.req_in  = 4'b1111;
        for (int i = 0; i < 41; i++) begin
            tick();
            chk("rr_seq", 32'(bus.gnt_out), rr_pattern(i));
        end
        bus.req_in = 4'b0100;
        tick();
        chk("sole_gap", 32'(bus.gnt_out), 32'd0);
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("sole_hold", 32'(bus.gnt_out), 32'h4);
        end

        // Release on the same edge the timeout would fire.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mode_in = 1'b0;
        bus.req_in  = 4'b0011;
        for (int i = 0; i < 8; i++) tick();
        bus.req_in = 4'b0010;
        tick();
        chk("collide_gap", 32'(bus.gnt_out), 32'd0);
        tick();
        chk("collide_next", 32'(bus.gnt_out), 32'h2);

        // Reset in the middle of a grant to requester 2.
        bus.mode_in = 1'b1;
        bus.req_in  = 4'b0100;
        tick();
        tick();
        tick();
        chk("mid_id", 32'(bus.gnt_id_out), 32'd2);
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", 32'(bus.gnt_out), 32'd0);
        chk("mid_rst_id", 32'(bus.gnt_id_out), 32'd0);
        rst = 1'b0;
        bus.req_in = 4'b1111;
        tick();
        chk("mid_rr_restart", 32'(bus.gnt_out), 32'h1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) bus.req_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) bus.mode_in = ~bus.mode_in;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
